exer_bg_strip_engine: RTL

Parametrised, single-clock background strip renderer for the Exerion core. It replaces the four fixed strip channels and their derived-clock latches with CHANNELS identical channels clocked on clk_sys and advanced by a pixel clock enable. Each channel walks a pixel address up or down across a line and prefetches 2bpp graphics bytes through one shared, arbitrated ROM port. A priority stage outputs the winning 2-bit pixel and its channel index to the palette PROM lookup.

---
 rtl/exer_bg_strip_engine.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/exer_bg_strip_engine.sv
// Background strip renderer: CHANNELS strip channels sharing one arbitrated 2bpp ROM port, plus a priority mux.
// Optional build macro EXER_BG_UNDERRUN_PROTECT_EN: an underrunning channel repeats its last pixel instead of 0.

module exer_bg_strip_chan #(
  parameter int HI_W  = 8,
  parameter int LEN_W = 8
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            pix_ce,
  input  logic            line_start,
  input  logic            r2UP,
  input  logic            wr_hi,
  input  logic            wr_lo,
  input  logic            wr_len,
  input  logic [7:0]      reg_data,
  input  logic            fill,
  input  logic            fill_slot,
  input  logic [7:0]      fill_data,
  output logic            need,
  output logic            need_slot,
  output logic [HI_W+4:0] fetch_addr,
  output logic            inval,
  output logic [1:0]      pix,
  output logic            underrun
);
  logic [HI_W-1:0]  hi;
  logic [7:0]       lo_base, lo, cur, nxt;
  logic [LEN_W-1:0] len, cnt;
  logic             cur_v, nxt_v, active, step, shift;
  logic [5:0]       nxt_idx;
  logic [1:0]       cur_pix;
`ifdef EXER_BG_UNDERRUN_PROTECT_EN
  logic [1:0]       last_pix;
`endif

  assign active     = cnt != '0;
  assign step       = pix_ce & active;
  assign shift      = step & (r2UP ? (lo[1:0] == 2'b00) : (lo[1:0] == 2'b11));
  assign inval      = line_start | shift;
  assign nxt_idx    = r2UP ? lo[7:2] - 6'd1 : lo[7:2] + 6'd1;
  // bit 5 of a byte index is lo[7]: those bytes are blank and never fetched
  assign need_slot  = cur_v;
  assign need       = active & (cur_v ? (!nxt_v & !nxt_idx[5]) : !lo[7]);
  assign fetch_addr = {hi, cur_v ? nxt_idx[4:0] : lo[6:2]};
  assign cur_pix    = {cur[{1'b1, lo[1:0]}], cur[{1'b0, lo[1:0]}]};

  always_comb begin
    pix = 2'b00;
    if (active) begin
      if (cur_v) pix = cur_pix;
`ifdef EXER_BG_UNDERRUN_PROTECT_EN
      else       pix = last_pix;
`endif
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hi <= '0; lo_base <= '0; len <= '0; lo <= '0; cnt <= '0;
      cur <= '0; nxt <= '0; cur_v <= 1'b0; nxt_v <= 1'b0; underrun <= 1'b0;
`ifdef EXER_BG_UNDERRUN_PROTECT_EN
      last_pix <= '0;
`endif
    end else begin
      if (wr_hi)  hi      <= reg_data[HI_W-1:0];
      if (wr_lo)  lo_base <= reg_data;
      if (wr_len) len     <= reg_data[LEN_W-1:0];
      if (line_start) begin
        // a same-cycle register write is the value the new line starts from
        lo    <= wr_lo  ? reg_data : lo_base;
        cnt   <= wr_len ? reg_data[LEN_W-1:0] : len;
        cur_v <= 1'b0;
        nxt_v <= 1'b0;
      end else begin
        if (step) begin
          lo  <= r2UP ? lo - 8'd1 : lo + 8'd1;
          cnt <= cnt - 1'b1;
          if (!cur_v) underrun <= 1'b1;
`ifdef EXER_BG_UNDERRUN_PROTECT_EN
          else        last_pix <= cur_pix;
`endif
        end
        if (shift) begin
          cur   <= nxt;
          cur_v <= nxt_v;
          nxt_v <= 1'b0;
        end else begin
          if (!cur_v && lo[7]) begin
            cur <= 8'h00; cur_v <= 1'b1;
          end else if (fill && !fill_slot) begin
            cur <= fill_data; cur_v <= 1'b1;
          end
          if (cur_v && !nxt_v && nxt_idx[5]) begin
            nxt <= 8'h00; nxt_v <= 1'b1;
          end else if (fill && fill_slot) begin
            nxt <= fill_data; nxt_v <= 1'b1;
          end
        end
      end
    end
  end
endmodule

module exer_bg_strip_engine #(
  parameter int CHANNELS = 4,
  parameter int HI_W     = 8,
  parameter int LEN_W    = 8,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                pix_ce,
  input  logic                line_start,
  input  logic                r2UP,
  input  logic                nVDSP,
  input  logic                reg_we,
  input  logic [CW-1:0]       reg_ch,
  input  logic [1:0]          reg_field,
  input  logic [7:0]          reg_data,
  output logic                rom_req,
  output logic [CW-1:0]       rom_ch,
  output logic [HI_W+4:0]     rom_addr,
  input  logic                rom_ack,
  input  logic [7:0]          rom_data,
  output logic [1:0]          bg_pix,
  output logic [CW-1:0]       bg_ch,
  output logic [7:0]          scene,
  output logic [CHANNELS-1:0] underrun
);
  typedef enum logic {IDLE, REQ} arb_t;
  arb_t state, state_n;

  logic [CHANNELS-1:0]            need, need_slot, inval, fill, wr_hi, wr_lo, wr_len;
  logic [CHANNELS-1:0][HI_W+4:0]  fetch_addr;
  logic [CHANNELS-1:0][1:0]       pix;
  logic [CW-1:0]                  last_gnt, pick, cand, win_ch;
  logic                           pick_v, req_slot, stale;
  logic [1:0]                     win_pix;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign wr_hi[g]  = reg_we && reg_field == 2'b00 && reg_ch == CW'(g);
    assign wr_lo[g]  = reg_we && reg_field == 2'b01 && reg_ch == CW'(g);
    assign wr_len[g] = reg_we && reg_field == 2'b10 && reg_ch == CW'(g);
    // data for a slot invalidated while the request was outstanding is dropped
    assign fill[g]   = state == REQ && rom_ack && !stale && !inval[g] && rom_ch == CW'(g);

    exer_bg_strip_chan #(.HI_W(HI_W), .LEN_W(LEN_W)) u_ch (
      .clk_sys(clk_sys), .reset(reset), .pix_ce(pix_ce), .line_start(line_start), .r2UP(r2UP),
      .wr_hi(wr_hi[g]), .wr_lo(wr_lo[g]), .wr_len(wr_len[g]), .reg_data(reg_data),
      .fill(fill[g]), .fill_slot(req_slot), .fill_data(rom_data),
      .need(need[g]), .need_slot(need_slot[g]), .fetch_addr(fetch_addr[g]),
      .inval(inval[g]), .pix(pix[g]), .underrun(underrun[g])
    );
  end

  // round-robin: scan downward so the nearest channel after last_gnt wins
  always_comb begin
    pick   = '0;
    pick_v = 1'b0;
    cand   = '0;
    for (int i = CHANNELS; i >= 1; i--) begin
      cand = CW'((int'(last_gnt) + i) % CHANNELS);
      if (need[cand]) begin
        pick   = cand;
        pick_v = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (pick_v)  state_n = REQ;
      REQ:     if (rom_ack) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign rom_req = state == REQ;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      rom_ch   <= '0;
      rom_addr <= '0;
      req_slot <= 1'b0;
      stale    <= 1'b0;
      last_gnt <= CW'(CHANNELS - 1);
    end else begin
      state <= state_n;
      if (state == IDLE && pick_v) begin
        rom_ch   <= pick;
        rom_addr <= fetch_addr[pick];
        req_slot <= need_slot[pick];
        stale    <= inval[pick];
        last_gnt <= pick;
      end else if (state == REQ) begin
        stale    <= stale | inval[rom_ch];
      end
    end
  end

  always_comb begin
    win_pix = 2'b00;
    win_ch  = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (pix[i] != 2'b00) begin
        win_pix = pix[i];
        win_ch  = CW'(i);
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bg_pix <= '0;
      bg_ch  <= '0;
      scene  <= '0;
    end else begin
      if (reg_we && reg_field == 2'b11) scene <= reg_data;
      if (pix_ce) begin
        bg_pix <= nVDSP ? 2'b00 : win_pix;
        bg_ch  <= nVDSP ? '0    : win_ch;
      end
    end
  end
endmodule
